alu_ft_bist_nway: RTL and testbench

Parametrised N-way fault-tolerant ALU with on-line built-in self-test for the RISC-V execute stage. It holds `NUM_UNITS` identical ALU lanes and one internal LFSR pattern generator, MISR signature register and BIST controller. While the datapath keeps serving instructions, the controller tests one healthy lane at a time in round-robin order. A lane whose signature mismatches is retired permanently, and traffic stays on a healthy lane.

---
 rtl/alu_ft_bist_nway.sv | 195 +++++++++++++++++++
 tb/tb_alu_ft_bist_nway.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ft_bist_nway.sv
// N-way fault-tolerant ALU: identical lanes, one tested at a time by an LFSR/MISR BIST engine.
// Datapath is combinational; BIST control is registered and retires lanes whose signature mismatches.
module alu_ft_bist_nway #(
  parameter int          WIDTH        = 32,
  parameter int          NUM_UNITS    = 3,
  parameter int          NUM_PATTERNS = 64,
  parameter logic [31:0] LFSR_SEED    = 32'hACE1_0001,
  parameter logic [31:0] LFSR_TAPS    = 32'h8020_0003,
  parameter logic [31:0] MISR_TAPS    = 32'h04C1_1DB7,
  parameter logic [31:0] GOLDEN_SIG   = 32'h0,
  parameter int          AUTO_PERIOD  = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             A,
  input  logic [WIDTH-1:0]             B,
  input  logic [2:0]                   ALUControl,
  input  logic [NUM_UNITS-1:0]         force_fault,
  input  logic                         bist_start,
  output logic [WIDTH-1:0]             Result,
  output logic                         Carry,
  output logic                         OverFlow,
  output logic                         Zero,
  output logic                         Negative,
  output logic                         bist_busy,
  output logic                         bist_done,
  output logic                         bist_pass,
  output logic [NUM_UNITS-1:0]         fault_map,
  output logic [$clog2(NUM_UNITS)-1:0] active_unit,
  output logic                         degraded
);
  localparam int UW  = $clog2(NUM_UNITS);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(NUM_PATTERNS + 1);
  localparam logic [WIDTH-1:0] SEED_W   = WIDTH'(LFSR_SEED);
  localparam logic [WIDTH-1:0] LTAPS_W  = WIDTH'(LFSR_TAPS);
  localparam logic [WIDTH-1:0] MTAPS_W  = WIDTH'(MISR_TAPS);
  localparam logic [WIDTH-1:0] GOLDEN_W = WIDTH'(GOLDEN_SIG);

  typedef enum logic [1:0] {S_IDLE, S_SEED, S_RUN, S_CHECK} state_t;

  state_t                 state_q;
  logic [WIDTH-1:0]       lfsr_q, misr_q, lfsr_d, misr_d;
  logic [CW-1:0]          cnt_q;
  logic [31:0]            timer_q;
  logic [UW-1:0]          target_q;
  logic [NUM_UNITS-1:0]   fault_map_q, map_d;
  logic                   done_q, pass_q, pass_d, auto_fire;
  logic [WIDTH-1:0]       lane_res [NUM_UNITS];
  logic [NUM_UNITS-1:0]   lane_c, lane_v;
  logic [WIDTH-1:0]       res_ut;
  logic                   c_ut;
  logic [UW-1:0]          first_h, second_h;
  logic [UW:0]            healthy_cnt;

  // Returns {overflow, carry, result}; SUB reuses the adder with inverted B and carry-in.
  function automatic logic [WIDTH+1:0] alu_eval(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                input logic [2:0] op);
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] bx, r;
    logic             c, v;
    bx  = (op == 3'b001) ? ~b : b;
    sum = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, (op == 3'b001)};
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'b000, 3'b001: begin
        r = sum[WIDTH-1:0];
        c = sum[WIDTH];
        v = (a[WIDTH-1] == bx[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b100:  r = a ^ b;
      3'b101:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      3'b110:  r = a >> b[SHW-1:0];
      default: r = b;
    endcase
    return {v, c, r};
  endfunction

  function automatic logic [UW-1:0] next_healthy(input logic [UW-1:0] cur, input logic [NUM_UNITS-1:0] map);
    logic [UW-1:0] wrap, hi;
    logic          hi_found;
    wrap = cur; hi = cur; hi_found = 1'b0;
    for (int j = NUM_UNITS - 1; j >= 0; j--) begin
      if (!map[j]) wrap = UW'(j);
      if (!map[j] && (UW'(j) > cur)) begin
        hi       = UW'(j);
        hi_found = 1'b1;
      end
    end
    return hi_found ? hi : wrap;
  endfunction

  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_lane
    logic             under_test;
    logic [WIDTH-1:0] la, lb;
    logic [2:0]       lop;
    logic [WIDTH+1:0] o;
    always_comb begin
      under_test = bist_busy && (target_q == UW'(i));
      la  = under_test ? lfsr_q : A;
      lb  = under_test ? ~lfsr_q : B;
      lop = under_test ? lfsr_q[2:0] : ALUControl;
      o   = alu_eval(la, lb, lop);
    end
    assign lane_res[i] = o[WIDTH-1:0] ^ {{(WIDTH-1){1'b0}}, force_fault[i]};
    assign lane_c[i]   = o[WIDTH];
    assign lane_v[i]   = o[WIDTH+1];
  end

  // Lane selection depends only on registered BIST state, never on the operands.
  always_comb begin
    first_h = '0; second_h = '0; healthy_cnt = '0;
    for (int i = NUM_UNITS - 1; i >= 0; i--) if (!fault_map_q[i]) first_h = UW'(i);
    for (int i = NUM_UNITS - 1; i >= 0; i--) if (!fault_map_q[i] && (UW'(i) != first_h)) second_h = UW'(i);
    for (int i = 0; i < NUM_UNITS; i++) healthy_cnt = healthy_cnt + {{UW{1'b0}}, ~fault_map_q[i]};
    active_unit = (bist_busy && (first_h == target_q)) ? second_h : first_h;
  end

  always_comb begin
    Result = '0; Carry = 1'b0; OverFlow = 1'b0; res_ut = '0; c_ut = 1'b0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (active_unit == UW'(i)) begin
        Result   = lane_res[i];
        Carry    = lane_c[i];
        OverFlow = lane_v[i];
      end
      if (target_q == UW'(i)) begin
        res_ut = lane_res[i];
        c_ut   = lane_c[i];
      end
    end
  end

  assign Zero      = (Result == '0);
  assign Negative  = Result[WIDTH-1];
  assign lfsr_d    = {lfsr_q[WIDTH-2:0], 1'b0} ^ (lfsr_q[WIDTH-1] ? LTAPS_W : '0);
  assign misr_d    = {misr_q[WIDTH-2:0], 1'b0} ^ (misr_q[WIDTH-1] ? MTAPS_W : '0) ^ res_ut
                     ^ {{(WIDTH-1){1'b0}}, c_ut};
  assign pass_d    = (misr_q == GOLDEN_W);
  assign map_d     = fault_map_q | (pass_d ? '0 : (NUM_UNITS'(1) << target_q));
  assign auto_fire = (AUTO_PERIOD > 0) && (state_q == S_IDLE) && (timer_q == 32'(AUTO_PERIOD - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      lfsr_q      <= SEED_W;
      misr_q      <= '0;
      cnt_q       <= '0;
      timer_q     <= '0;
      target_q    <= '0;
      fault_map_q <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (AUTO_PERIOD > 0) timer_q <= auto_fire ? '0 : timer_q + 32'd1;
          // A test needs a spare lane to carry traffic while the target is busy.
          if ((bist_start || auto_fire) && (healthy_cnt >= (UW+1)'(2))) begin
            state_q <= S_SEED;
            timer_q <= '0;
          end
        end
        S_SEED: begin
          lfsr_q  <= SEED_W;
          misr_q  <= '0;
          cnt_q   <= '0;
          state_q <= S_RUN;
        end
        S_RUN: begin
          misr_q <= misr_d;
          lfsr_q <= lfsr_d;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(NUM_PATTERNS - 1)) state_q <= S_CHECK;
        end
        default: begin
          done_q      <= 1'b1;
          pass_q      <= pass_d;
          fault_map_q <= map_d;
          target_q    <= next_healthy(target_q, map_d);
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign bist_busy = (state_q != S_IDLE);
  assign bist_done = done_q;
  assign bist_pass = pass_q;
  assign fault_map = fault_map_q;
  assign degraded  = (healthy_cnt == (UW+1)'(1));
endmodule

// File: tb/tb_alu_ft_bist_nway.sv
// Directed bench for alu_ft_bist_nway: functional ops, BIST timing, lane retirement, degradation,
// auto-trigger (second instance) and mid-test reset. Golden signature comes from a local reference model.
module tb_alu_ft_bist_nway;
  localparam logic [31:0] SEED   = 32'hACE1_0001;
  localparam logic [31:0] LTAPS  = 32'h8020_0003;
  localparam logic [31:0] MTAPS  = 32'h04C1_1DB7;

  function automatic logic [32:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    logic [32:0] s;
    case (op)
      3'd0:    s = {1'b0, a} + {1'b0, b};
      3'd1:    s = {1'b0, a} + {1'b0, ~b} + 33'd1;
      3'd2:    s = {1'b0, a & b};
      3'd3:    s = {1'b0, a | b};
      3'd4:    s = {1'b0, a ^ b};
      3'd5:    s = {32'd0, ($signed(a) < $signed(b))};
      3'd6:    s = {1'b0, a >> b[4:0]};
      default: s = {1'b0, b};
    endcase
    return s;
  endfunction

  function automatic logic [31:0] calc_golden();
    logic [31:0] l, m;
    logic [32:0] r;
    l = SEED; m = 32'd0;
    for (int i = 0; i < 64; i++) begin
      r = ref_alu(l, ~l, l[2:0]);
      m = {m[30:0], 1'b0} ^ (m[31] ? MTAPS : 32'd0) ^ r[31:0] ^ {31'd0, r[32]};
      l = {l[30:0], 1'b0} ^ (l[31] ? LTAPS : 32'd0);
    end
    return m;
  endfunction

  localparam logic [31:0] GOLDEN = calc_golden();

  logic        clk = 1'b0;
  logic        rst, rst2, bist_start, start2;
  logic [31:0] A, B;
  logic [2:0]  ALUControl, force_fault;
  logic [31:0] Result, r2_res;
  logic        Carry, OverFlow, Zero, Negative, bist_busy, bist_done, bist_pass, degraded;
  logic        r2_c, r2_v, r2_z, r2_n, busy2, done2, pass2, deg2;
  logic [2:0]  fault_map, fmap2;
  logic [1:0]  active_unit, au2;

  int n_checks = 0, n_fail = 0, lane1_bad = 0;
  logic [1:0]  au_busy;
  logic [31:0] res_busy;
  logic        c_busy, z_busy;

  always #5 clk = ~clk;

  alu_ft_bist_nway #(.GOLDEN_SIG(GOLDEN)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .ALUControl(ALUControl), .force_fault(force_fault),
    .bist_start(bist_start), .Result(Result), .Carry(Carry), .OverFlow(OverFlow), .Zero(Zero),
    .Negative(Negative), .bist_busy(bist_busy), .bist_done(bist_done), .bist_pass(bist_pass),
    .fault_map(fault_map), .active_unit(active_unit), .degraded(degraded));

  alu_ft_bist_nway #(.GOLDEN_SIG(GOLDEN), .AUTO_PERIOD(10)) dut_auto (
    .clk(clk), .rst(rst2), .A(A), .B(B), .ALUControl(ALUControl), .force_fault(force_fault),
    .bist_start(start2), .Result(r2_res), .Carry(r2_c), .OverFlow(r2_v), .Zero(r2_z),
    .Negative(r2_n), .bist_busy(busy2), .bist_done(done2), .bist_pass(pass2),
    .fault_map(fmap2), .active_unit(au2), .degraded(deg2));

  always @(negedge clk) if (rst && fault_map[1] && active_unit == 2'd1) lane1_bad++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, 32'(bist_busy), 0);
    check({tag, "_done"}, 32'(bist_done), 0);
    check({tag, "_pass"}, 32'(bist_pass), 0);
    check({tag, "_fmap"}, 32'(fault_map), 0);
    check({tag, "_active"}, 32'(active_unit), 0);
    check({tag, "_degraded"}, 32'(degraded), 0);
  endtask

  // Pulse bist_start, capture outputs in the first busy cycle, then time the whole test.
  task automatic run_test(input string tag, input logic exp_pass, input logic [2:0] exp_map);
    int n;
    n = 0;
    bist_start = 1'b1;
    @(negedge clk); #1;
    bist_start = 1'b0;
    au_busy = active_unit; res_busy = Result; c_busy = Carry; z_busy = Zero;
    while (bist_busy && n < 200) begin
      n++;
      @(negedge clk); #1;
    end
    check({tag, "_busy_len"}, 32'(n), 66);
    check({tag, "_done"}, 32'(bist_done), 1);
    check({tag, "_pass"}, 32'(bist_pass), 32'(exp_pass));
    check({tag, "_fmap"}, 32'(fault_map), 32'(exp_map));
    @(negedge clk); #1;
    check({tag, "_done_pulse"}, 32'(bist_done), 0);
  endtask

  task automatic busy_len2(output int n);
    n = 0;
    while (busy2 && n < 200) begin
      n++;
      @(negedge clk); #1;
    end
  endtask

  task automatic idle_len2(output int n, output int dones);
    n = 0; dones = 0;
    do begin
      @(negedge clk); #1;
      n++;
      if (done2) dones++;
    end while (!busy2 && n < 50);
  endtask

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a, b, res;
    logic        c, v;
  } vec_t;

  vec_t vecs [9] = '{
    '{3'd1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1},
    '{3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1},
    '{3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0},
    '{3'd3, 32'h0F0F_0000, 32'h0000_F0F0, 32'h0F0F_F0F0, 1'b0, 1'b0},
    '{3'd4, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b0, 1'b0},
    '{3'd5, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0},
    '{3'd5, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0},
    '{3'd6, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1'b0, 1'b0},
    '{3'd7, 32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0}
  };

  initial begin
    int n, dones, busy_cnt, done_cnt;
    rst = 1'b0; rst2 = 1'b0; bist_start = 1'b0; start2 = 1'b0;
    A = '0; B = '0; ALUControl = '0; force_fault = '0;
    repeat (3) @(negedge clk);
    #1 check_reset("rst");
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      A = vecs[i].a; B = vecs[i].b; ALUControl = vecs[i].op;
      #1;
      check($sformatf("vec%0d_res", i), Result, vecs[i].res);
      check($sformatf("vec%0d_carry", i), 32'(Carry), 32'(vecs[i].c));
      check($sformatf("vec%0d_ovf", i), 32'(OverFlow), 32'(vecs[i].v));
      check($sformatf("vec%0d_zero", i), 32'(Zero), 32'(vecs[i].res == 32'd0));
      check($sformatf("vec%0d_neg", i), 32'(Negative), 32'(vecs[i].res[31]));
    end

    @(negedge clk);
    A = 32'hFFFF_FFFF; B = 32'h1; ALUControl = 3'd0;
    run_test("t1_lane0", 1'b1, 3'b000);
    check("t1_active_in_busy", 32'(au_busy), 1);
    check("t1_add_res", res_busy, 0);
    check("t1_add_carry", 32'(c_busy), 1);
    check("t1_add_zero", 32'(z_busy), 1);

    force_fault = 3'b010;
    run_test("t2_lane1", 1'b0, 3'b010);
    check("t2_active_in_busy", 32'(au_busy), 0);
    run_test("t3_lane2", 1'b1, 3'b010);
    check("t3_active_in_busy", 32'(au_busy), 0);

    force_fault = 3'b001;
    A = 32'd2; B = 32'd3; ALUControl = 3'd0;
    #1 check("no_switchover_res", Result, 32'd4);
    run_test("t4_lane0", 1'b0, 3'b011);
    check("t4_active_in_busy", 32'(au_busy), 2);
    check("deg_flag", 32'(degraded), 1);
    check("deg_active", 32'(active_unit), 2);
    check("deg_res", Result, 32'd5);

    bist_start = 1'b1;
    @(negedge clk);
    bist_start = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    repeat (70) begin
      @(negedge clk); #1;
      if (bist_busy) busy_cnt++;
      if (bist_done) done_cnt++;
    end
    check("deg_no_busy", 32'(busy_cnt), 0);
    check("deg_no_done", 32'(done_cnt), 0);

    rst = 1'b0; force_fault = '0;
    @(negedge clk); rst = 1'b1;
    run_test("r1_lane0", 1'b1, 3'b000);
    force_fault = 3'b010;
    run_test("r2_lane1", 1'b0, 3'b010);
    bist_start = 1'b1;
    @(negedge clk);
    bist_start = 1'b0;
    repeat (20) @(negedge clk);
    #1 check("midrun_busy", 32'(bist_busy), 1);
    rst = 1'b0;
    #1 check_reset("midrun_rst");
    repeat (2) @(negedge clk);
    rst = 1'b1; force_fault = '0;
    run_test("after_rst", 1'b1, 3'b000);
    check("after_rst_active", 32'(au_busy), 1);
    check("lane1_never_active", 32'(lane1_bad), 0);

    @(negedge clk);
    rst2 = 1'b1;
    idle_len2(n, dones);
    check("auto_first_gap", 32'(n), 10);
    busy_len2(n);
    check("auto_busy_len", 32'(n), 66);
    check("auto_done", 32'(done2), 1);
    check("auto_pass", 32'(pass2), 1);
    idle_len2(n, dones);
    check("auto_gap", 32'(n), 10);
    busy_len2(n);
    check("auto_busy_len2", 32'(n), 66);
    repeat (9) @(negedge clk);
    #1 check("coinc_idle", 32'(busy2), 0);
    start2 = 1'b1;
    @(negedge clk); #1;
    start2 = 1'b0;
    check("coinc_started", 32'(busy2), 1);
    busy_len2(n);
    check("coinc_busy_len", 32'(n), 66);
    check("coinc_done", 32'(done2), 1);
    idle_len2(n, dones);
    check("coinc_single_gap", 32'(n), 10);
    check("coinc_extra_done", 32'(dones), 0);
    check("auto_fmap", 32'(fmap2), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
